// File: rtl/div_unit.sv
// Multi-cycle restoring divider: 32 quotient bits MSB-first, result {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise every divide is unsigned.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [64:0] r_shift;
  logic [31:0] r_divisor;

  logic [32:0] w_top;
  logic [33:0] w_diff;
  logic [31:0] w_dividend_mag;
  logic [31:0] w_divisor_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Upper 33 bits hold the partial remainder, lower 32 shift in quotient bits.
  assign w_top  = r_shift[63:31];
  assign w_diff = {1'b0, w_top} - {2'b00, r_divisor};

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_sgn1;
  logic w_sgn2;
  logic w_unused;

  assign w_sgn1         = signed_div_i & opdata1_i[31];
  assign w_sgn2         = signed_div_i & opdata2_i[31];
  assign w_dividend_mag = w_sgn1 ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_divisor_mag  = w_sgn2 ? (~opdata2_i + 32'd1) : opdata2_i;
  assign w_quot         = r_neg_q ? (~r_shift[31:0] + 32'd1) : r_shift[31:0];
  assign w_rem          = r_neg_r ? (~r_shift[63:32] + 32'd1) : r_shift[63:32];
  assign w_unused       = r_shift[64];

  always_ff @(posedge clk) begin
    if (r_state == S_FREE && start_i && !annul_i) begin
      r_neg_q <= w_sgn1 ^ w_sgn2;
      r_neg_r <= w_sgn1;
    end
  end
`else
  logic [1:0] w_unused;

  assign w_dividend_mag = opdata1_i;
  assign w_divisor_mag  = opdata2_i;
  assign w_quot         = r_shift[31:0];
  assign w_rem          = r_shift[63:32];
  assign w_unused       = {signed_div_i, r_shift[64]};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_FREE;
      r_cnt    <= 6'd0;
      ready_o  <= 1'b0;
      result_o <= 64'd0;
    end else begin
      case (r_state)
        S_FREE: begin
          if (start_i && !annul_i) begin
            r_divisor <= w_divisor_mag;
            r_shift   <= {33'd0, w_dividend_mag};
            r_cnt     <= 6'd0;
            r_state   <= (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            r_state <= S_FREE;
          end else begin
            r_state  <= S_END;
            ready_o  <= 1'b1;
            result_o <= 64'd0;
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_state <= S_FREE;
            r_cnt   <= 6'd0;
          end else if (r_cnt != 6'd32) begin
            // Restoring step: keep the subtraction only when it did not borrow.
            if (w_diff[33])
              r_shift <= {w_top, r_shift[30:0], 1'b0};
            else
              r_shift <= {w_diff[32:0], r_shift[30:0], 1'b1};
            r_cnt <= r_cnt + 6'd1;
          end else begin
            result_o <= {w_rem, w_quot};
            ready_o  <= 1'b1;
            r_state  <= S_END;
          end
        end
        S_END: begin
          if (!start_i) begin
            r_state  <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end
        default: r_state <= S_FREE;
      endcase
    end
  end

endmodule
